// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared state codes, handshake constants and widths for the divider
package div_unit_pkg;
  localparam int DIV_DATA_W = 32;
  localparam logic RstEnable = 1'b0;
  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;
  typedef enum logic {DivResultNotReady = 1'b0, DivResultReady = 1'b1} div_ready_e;
  typedef enum logic {DivStop = 1'b0, DivStart = 1'b1} div_start_e;
  typedef enum logic {NoStop = 1'b0, Stop = 1'b1} stall_e;
endpackage

// File: rtl/div_unit_if.sv
// div_unit_if: EX-stage request/result bundle between the pipeline and the divider
interface div_unit_if
  import div_unit_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
);
  logic                start_i;
  logic                annul_i;
  logic                signed_div_i;
  logic [DATA_W-1:0]   opdata1_i;
  logic [DATA_W-1:0]   opdata2_i;
  logic [2*DATA_W-1:0] result_o;
  logic                ready_o;
  logic                stallreq_o;
  modport master(
    output start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    input  result_o, ready_o, stallreq_o
  );
  modport slave(
    input  start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    output result_o, ready_o, stallreq_o
  );
endinterface

// File: rtl/div_unit_step.sv
// div_unit_step: one restoring iteration, shift in a dividend bit and try to subtract
module div_unit_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_rem,
  input  logic [DATA_W-1:0] i_divisor,
  input  logic              i_bit,
  output logic [DATA_W-1:0] o_rem,
  output logic              o_qbit
);
  logic [DATA_W:0] w_shift;
  logic [DATA_W:0] w_diff;
  // one extra bit keeps the shifted remainder exact for divisors above 2^(DATA_W-1)
  assign w_shift = {i_rem, i_bit};
  assign w_diff  = w_shift - {1'b0, i_divisor};
  assign o_qbit  = ~w_diff[DATA_W];
  assign o_rem   = o_qbit ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];
endmodule

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring DIV/DIVU with pipeline stall request
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input logic clk,
  input logic rst,
  div_unit_if.slave bus
);
  localparam int CW = $clog2(DATA_W);
  div_state_e          r_state, w_next;
  logic [CW-1:0]       r_cnt;
  logic [DATA_W-1:0]   r_dvd, r_dvs, r_rem;
  logic [DATA_W-1:0]   w_rem, w_quot, w_abs1, w_abs2;
  logic                r_neg_q, r_neg_r, r_ready;
  logic [2*DATA_W-1:0] r_result;
  logic                w_qbit, w_go, w_last;
  assign w_go   = (bus.start_i == DivStart) && !bus.annul_i;
  assign w_last = r_cnt == CW'(DATA_W - 1);
  assign w_abs1 = bus.signed_div_i && bus.opdata1_i[DATA_W-1] ? -bus.opdata1_i : bus.opdata1_i;
  assign w_abs2 = bus.signed_div_i && bus.opdata2_i[DATA_W-1] ? -bus.opdata2_i : bus.opdata2_i;
  // the dividend register shifts out its bits while quotient bits shift in behind them
  assign w_quot = {r_dvd[DATA_W-2:0], w_qbit};
  div_unit_step #(.DATA_W(DATA_W)) u_step (
    .i_rem    (r_rem),
    .i_divisor(r_dvs),
    .i_bit    (r_dvd[DATA_W-1]),
    .o_rem    (w_rem),
    .o_qbit   (w_qbit)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      DivFree:   w_next = w_go ? (bus.opdata2_i == '0 ? DivByZero : DivOn) : DivFree;
      DivByZero: w_next = bus.annul_i ? DivFree : DivEnd;
      DivOn:     w_next = bus.annul_i ? DivFree : (w_last ? DivEnd : DivOn);
      default:   w_next = DivFree;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_state  <= DivFree;
      r_cnt    <= '0;
      r_result <= '0;
      r_ready  <= DivResultNotReady;
    end else begin
      r_state <= w_next;
      r_ready <= w_next == DivEnd ? DivResultReady : DivResultNotReady;
      if (r_state == DivFree && w_next == DivOn) begin
        r_dvd   <= w_abs1;
        r_dvs   <= w_abs2;
        r_rem   <= '0;
        r_cnt   <= '0;
        r_neg_q <= bus.signed_div_i && (bus.opdata1_i[DATA_W-1] ^ bus.opdata2_i[DATA_W-1]);
        r_neg_r <= bus.signed_div_i && bus.opdata1_i[DATA_W-1];
      end
      if (r_state == DivOn) begin
        r_dvd <= w_quot;
        r_rem <= w_rem;
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == DivByZero && w_next == DivEnd) r_result <= '0;
      if (r_state == DivOn && w_next == DivEnd)
        r_result <= {r_neg_r ? -w_rem : w_rem, r_neg_q ? -w_quot : w_quot};
    end
  end
  assign bus.result_o   = r_result;
  assign bus.ready_o    = r_ready;
  assign bus.stallreq_o = w_go && r_state != DivEnd ? Stop : NoStop;
endmodule
